modport_rf: RTL and testbench

- Windowed register file with circular overlapping windows, call/return window shifting and automatic spill/fill to an external stack memory.
- Intended as the integer register file of a RISC-style datapath.
- Two synchronous read ports and one write port, all addressed in logical (window-relative) space.
- Memory traffic is one word per cycle over mem_bus (spill) and mem_busRead (fill).

---
 rtl/modport_rf_if.sv | 34 +++
 rtl/modport_rf.sv | 172 +++++++++++++++++
 tb/tb_modport_rf.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/modport_rf_if.sv
// Command, read-data and stack-memory bundle of the windowed register file.
interface modport_rf_if #(
    parameter int NBITS     = 64,
    parameter int ADDR_SIZE = 4
);
    logic                 enable;
    logic                 rd1;
    logic                 rd2;
    logic                 wr;
    logic                 call;
    logic                 sigreturn;
    logic [ADDR_SIZE-1:0] add_wr;
    logic [ADDR_SIZE-1:0] add_rd1;
    logic [ADDR_SIZE-1:0] add_rd2;
    logic [NBITS-1:0]     data_in;
    logic [NBITS-1:0]     out1;
    logic [NBITS-1:0]     out2;
    logic [NBITS-1:0]     mem_bus;
    logic [NBITS-1:0]     mem_busRead;
    logic                 fill;
    logic                 spill;

    modport master (
        output enable, rd1, rd2, wr, call, sigreturn,
        output add_wr, add_rd1, add_rd2, data_in, mem_busRead,
        input  out1, out2, mem_bus, fill, spill
    );

    modport slave (
        input  enable, rd1, rd2, wr, call, sigreturn,
        input  add_wr, add_rd1, add_rd2, data_in, mem_busRead,
        output out1, out2, mem_bus, fill, spill
    );
endinterface

// File: rtl/modport_rf.sv
// Windowed integer register file: circular overlapping windows,
// call/return shifting and one-word-per-cycle spill/fill to a stack memory.
module modport_rf #(
    parameter int NBITS      = 64,
    parameter int NREGISTERS = 32,
    parameter int N          = 3,
    parameter int F          = 4,
    parameter int M          = 5,
    parameter int ADDR_SIZE  = $clog2(3*N+M+1)
) (
    input  logic         clk,
    input  logic         rst,
    modport_rf_if.slave  bus
);
    localparam int WR = 2*N*F + 0*NREGISTERS;
    localparam int PW = $clog2(WR);
    localparam int GW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (F > 1) ? $clog2(F) : 1;
    localparam int KW = (N > 1) ? $clog2(2*N) : 1;
    localparam logic [CW-1:0] FMAX  = CW'(F-1);
    localparam logic [KW-1:0] KLAST = KW'(2*N-1);

    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

    state_t           state, state_n;
    logic [NBITS-1:0] win  [WR];
    logic [NBITS-1:0] glob [M];
    logic [CW-1:0]    cwp, swp, used;
    logic [7:0]       spilled;
    logic [KW-1:0]    cnt;
    logic             go, do_call, do_ret, last;
    logic [NBITS-1:0] rdata1, rdata2;
    logic [PW-1:0]    spill_nxt, fill_idx;

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] w);
        return (w == FMAX) ? '0 : w + 1'b1;
    endfunction

    function automatic logic [CW-1:0] dec(input logic [CW-1:0] w);
        return (w == '0) ? FMAX : w - 1'b1;
    endfunction

    function automatic logic [PW-1:0] win_base(input logic [CW-1:0] w);
        return PW'(2*N*int'(w));
    endfunction

    // OUT of window w lands on IN of window w+1 through the wrap.
    function automatic logic [PW-1:0] phys(
        input logic [CW-1:0]        w,
        input logic [ADDR_SIZE-1:0] a
    );
        int s;
        s = 2*N*int'(w) + int'(a);
        if (s >= WR) s = s - WR;
        return PW'(s);
    endfunction

    function automatic logic [GW-1:0] gidx(input logic [ADDR_SIZE-1:0] a);
        return GW'(int'(a) - 3*N);
    endfunction

    function automatic logic [NBITS-1:0] rd_val(
        input logic [ADDR_SIZE-1:0] a
    );
        logic valid, wt;
        rd_val = '0;
        valid  = int'(a) < 3*N+M;
        wt     = bus.wr && (a == bus.add_wr);
        unique case (1'b1)
            valid && wt:                 rd_val = bus.data_in;
            int'(a) < 3*N && !wt:        rd_val = win[phys(cwp, a)];
            valid && int'(a) >= 3*N && !wt:
                                         rd_val = glob[gidx(a)];
            default:                     rd_val = '0;
        endcase
    endfunction

    always_comb begin
        rdata1 = rd_val(bus.add_rd1);
        rdata2 = rd_val(bus.add_rd2);
    end

    always_comb begin
        go        = bus.enable && (state == IDLE);
        do_call   = go && bus.call && !bus.sigreturn;
        do_ret    = go && bus.sigreturn && !bus.call;
        last      = (cnt == KLAST);
        spill_nxt = win_base(swp) + PW'(cnt) + 1'b1;
        fill_idx  = win_base(swp) + PW'(KLAST - cnt);
        state_n   = state;
        unique case (state)
            IDLE: begin
                if (do_call && used == FMAX)
                    state_n = SPILL;
                else if (do_ret && used == CW'(1) && spilled != '0)
                    state_n = FILL;
            end
            SPILL, FILL: if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WR; i++) win[i] <= '0;
            for (int i = 0; i < M; i++)  glob[i] <= '0;
            bus.out1    <= '0;
            bus.out2    <= '0;
            bus.mem_bus <= '0;
            cwp         <= '0;
            swp         <= '0;
            used        <= CW'(1);
            spilled     <= '0;
            cnt         <= '0;
        end else begin
            if (go && bus.rd1) bus.out1 <= rdata1;
            if (go && bus.rd2) bus.out2 <= rdata2;
            if (go && bus.wr) begin
                if (int'(bus.add_wr) < 3*N)
                    win[phys(cwp, bus.add_wr)] <= bus.data_in;
                else if (int'(bus.add_wr) < 3*N+M)
                    glob[gidx(bus.add_wr)] <= bus.data_in;
            end
            if (do_call) begin
                if (used != FMAX) begin
                    cwp  <= inc(cwp);
                    used <= used + 1'b1;
                end else begin
                    bus.mem_bus <= win[win_base(swp)];
                    cnt         <= '0;
                end
            end
            if (do_ret) begin
                if (used != CW'(1)) begin
                    cwp  <= dec(cwp);
                    used <= used - 1'b1;
                end else if (spilled != '0) begin
                    swp <= dec(swp);
                    cnt <= '0;
                end
            end
            if (state == SPILL) begin
                if (last) begin
                    swp <= inc(swp);
                    cwp <= inc(cwp);
                    if (spilled != '1) spilled <= spilled + 1'b1;
                end else begin
                    bus.mem_bus <= win[spill_nxt];
                    cnt         <= cnt + 1'b1;
                end
            end
            // Stack is LIFO: the last spilled word comes back first.
            if (state == FILL) begin
                win[fill_idx] <= bus.mem_busRead;
                if (last) begin
                    cwp     <= dec(cwp);
                    spilled <= spilled - 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.spill = (state == SPILL);
    assign bus.fill  = (state == FILL);
endmodule

// File: tb/tb_modport_rf.sv
// Directed bench for modport_rf: globals, window overlap,
// spill/fill sequencing, underflow and mid-transfer reset.
module tb_modport_rf;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    modport_rf_if #(.NBITS(64), .ADDR_SIZE(4)) bus ();

    modport_rf #(
        .NBITS(64), .NREGISTERS(32), .N(3), .F(4), .M(5), .ADDR_SIZE(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.enable      = 1'b1;
        bus.rd1         = 1'b0;
        bus.rd2         = 1'b0;
        bus.wr          = 1'b0;
        bus.call        = 1'b0;
        bus.sigreturn   = 1'b0;
        bus.add_wr      = '0;
        bus.add_rd1     = '0;
        bus.add_rd2     = '0;
        bus.data_in     = '0;
        bus.mem_busRead = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [63:0] d);
        bus.wr = 1'b1; bus.add_wr = a; bus.data_in = d;
        tick();
        bus.wr = 1'b0;
    endtask

    task automatic do_rd(input logic [3:0] a1, input logic [3:0] a2);
        bus.rd1 = 1'b1; bus.add_rd1 = a1;
        bus.rd2 = 1'b1; bus.add_rd2 = a2;
        tick();
        bus.rd1 = 1'b0; bus.rd2 = 1'b0;
    endtask

    task automatic do_call();
        bus.call = 1'b1;
        tick();
        bus.call = 1'b0;
    endtask

    task automatic do_ret();
        bus.sigreturn = 1'b1;
        tick();
        bus.sigreturn = 1'b0;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out1", bus.out1, 64'h0);
        chk("rst_out2", bus.out2, 64'h0);
        chk("rst_mem_bus", bus.mem_bus, 64'h0);
        chk("rst_fill", bus.fill, 1'b0);
        chk("rst_spill", bus.spill, 1'b0);
        rst = 1'b1;
        tick();

        // globals are shared by every window
        do_wr(4'd9, 64'hAA);
        do_call();
        do_rd(4'd9, 4'd9);
        chk("glob_w1_out1", bus.out1, 64'hAA);
        chk("glob_w1_out2", bus.out2, 64'hAA);
        do_call();
        do_rd(4'd9, 4'd0);
        chk("glob_w2_out1", bus.out1, 64'hAA);

        // OUT of window 0 is IN of window 1
        do_reset();
        do_wr(4'd6, 64'h11);
        do_call();
        do_rd(4'd0, 4'd14);
        chk("overlap_in", bus.out1, 64'h11);
        chk("addr14_zero", bus.out2, 64'h0);
        do_wr(4'd14, 64'h55);
        do_rd(4'd0, 4'd14);
        chk("addr14_wr_ignored", bus.out2, 64'h0);
        bus.wr = 1'b1; bus.add_wr = 4'd3; bus.data_in = 64'h77;
        bus.rd1 = 1'b1; bus.add_rd1 = 4'd3;
        tick();
        idle();
        chk("write_through", bus.out1, 64'h77);
        tick();
        chk("out1_hold", bus.out1, 64'h77);
        do_ret();
        do_rd(4'd6, 4'd3);
        chk("ret_w0_out", bus.out1, 64'h11);

        // three calls: the third spills window 0
        do_reset();
        for (int a = 0; a < 6; a++) do_wr(4'(a), 64'(a + 1));
        do_call();
        chk("call1_no_spill", bus.spill, 1'b0);
        do_call();
        chk("call2_no_spill", bus.spill, 1'b0);
        do_call();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("spill_flag_%0d", k), bus.spill, 1'b1);
            chk($sformatf("spill_data_%0d", k), bus.mem_bus, 64'(k + 1));
            tick();
        end
        chk("spill_done", bus.spill, 1'b0);
        chk("mem_bus_hold", bus.mem_bus, 64'd6);

        // window 3 OUT aliases window 0 IN; clobber it before the fill
        do_wr(4'd6, 64'hF0);
        do_wr(4'd7, 64'hF0);
        do_wr(4'd8, 64'hF0);
        do_ret();
        chk("ret1_no_fill", bus.fill, 1'b0);
        do_ret();
        chk("ret2_no_fill", bus.fill, 1'b0);
        do_ret();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fill_flag_%0d", k), bus.fill, 1'b1);
            bus.mem_busRead = 64'(6 - k);
            tick();
        end
        bus.mem_busRead = '0;
        chk("fill_done", bus.fill, 1'b0);
        for (int a = 0; a < 6; a++) begin
            do_rd(4'(a), 4'd9);
            chk($sformatf("filled_%0d", a), bus.out1, 64'(a + 1));
        end

        // underflow, simultaneous call/return, enable low
        do_reset();
        do_wr(4'd6, 64'h33);
        do_ret();
        chk("underflow_fill", bus.fill, 1'b0);
        do_rd(4'd6, 4'd0);
        chk("underflow_cwp", bus.out1, 64'h33);
        bus.call = 1'b1; bus.sigreturn = 1'b1;
        tick();
        idle();
        chk("both_no_spill", bus.spill, 1'b0);
        do_rd(4'd6, 4'd0);
        chk("both_ignored", bus.out1, 64'h33);
        bus.enable = 1'b0;
        bus.wr = 1'b1; bus.add_wr = 4'd6; bus.data_in = 64'h99;
        bus.call = 1'b1;
        tick();
        idle();
        do_rd(4'd6, 4'd0);
        chk("enable_low", bus.out1, 64'h33);

        // reset in the middle of a spill
        do_reset();
        for (int a = 0; a < 6; a++) do_wr(4'(a), 64'(a + 1));
        do_rd(4'd0, 4'd1);
        chk("pre_rst_out1", bus.out1, 64'd1);
        do_call();
        do_call();
        do_call();
        tick();
        tick();
        chk("mid_spill", bus.spill, 1'b1);
        rst = 1'b0;
        #1;
        chk("abort_spill", bus.spill, 1'b0);
        chk("abort_out1", bus.out1, 64'h0);
        chk("abort_out2", bus.out2, 64'h0);
        chk("abort_mem_bus", bus.mem_bus, 64'h0);
        rst = 1'b1;
        tick();
        do_rd(4'd0, 4'd9);
        chk("post_rst_rd0", bus.out1, 64'h0);
        do_rd(4'd5, 4'd2);
        chk("post_rst_rd5", bus.out1, 64'h0);
        chk("post_rst_rd2", bus.out2, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
